// File: rtl/nn_div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package nn_div_pkg;

  localparam int DIN0_WIDTH = 20;
  localparam int DIN1_WIDTH = 12;
  localparam int DOUT_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nn_udiv_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module nn_udiv_step
  import nn_div_pkg::*;
#(
  parameter int W = DIN1_WIDTH
) (
  input  logic [W:0]   prem,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   prem_next,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // Two guard bits: the shifted value never exceeds 2*divisor-1, so the MSB is purely the sign.
  assign shifted   = {prem, bit_in};
  assign trial     = shifted - {2'b00, divisor};
  assign q_bit     = ~trial[W+1];
  assign prem_next = q_bit ? trial[W:0] : shifted[W:0];

endmodule

// File: rtl/nn_udiv_20ns_12ns_seq.sv
// Sequential unsigned divider, one quotient bit per cycle, valid/ready on both sides.
// Define NN_UDIV_ZERO_FLAG_EN to add the div_by_zero output.
module nn_udiv_20ns_12ns_seq
  import nn_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_WIDTH,
  parameter int din1_WIDTH = DIN1_WIDTH,
  parameter int dout_WIDTH = DOUT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem
`ifdef NN_UDIV_ZERO_FLAG_EN
  ,
  output logic                  div_by_zero
`endif
);

  localparam int CNT_W = $clog2(din0_WIDTH);

  if (dout_WIDTH != din0_WIDTH) begin : g_bad_cfg
    $error("nn_udiv_20ns_12ns_seq ID=%0d: dout_WIDTH must equal din0_WIDTH", ID);
  end

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [dout_WIDTH-1:0] quo;
  logic [din1_WIDTH-1:0] divisor;
  logic [din1_WIDTH:0]   prem, prem_step;
  logic                  q_bit;

  nn_udiv_step #(.W(din1_WIDTH)) u_step (
    .prem      (prem),
    .bit_in    (quo[dout_WIDTH-1]),
    .divisor   (divisor),
    .prem_next (prem_step),
    .q_bit     (q_bit)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (din1 == '0) ? DONE : DIV;
      end
      DIV: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // quo starts as the dividend: its MSB feeds each step while quotient bits shift in at the LSB.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt     <= '0;
      quo     <= '0;
      divisor <= '0;
      prem    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            divisor <= din1;
            cnt     <= CNT_W'(din0_WIDTH - 1);
            if (din1 == '0) begin
              quo  <= '1;
              prem <= {1'b0, din0[din1_WIDTH-1:0]};
            end else begin
              quo  <= din0;
              prem <= '0;
            end
          end
        end
        DIV: begin
          quo  <= {quo[dout_WIDTH-2:0], q_bit};
          prem <= prem_step;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dout = quo;
  assign rem  = prem[din1_WIDTH-1:0];

`ifdef NN_UDIV_ZERO_FLAG_EN
  logic zflag;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)                   zflag <= 1'b0;
    else if (in_valid && in_ready)   zflag <= (din1 == '0);
  end

  assign div_by_zero = out_valid & zflag;
`endif

endmodule
